rd_buf_reader: RTL and testbench

- Read-side requester for the shared sample SRAM. The SRAM is owned by the read/write arbiter, in which writes have priority.
- Takes single-byte read commands from the MCU-facing interface and holds an auto-incrementing read address.
- Issues rd_req to the arbiter, waits for the rd_sta grant, and drives the SRAM read cycle.
- Returns each byte with a one-cycle valid strobe. If a write pre-empts it mid-access, it retries transparently.

---
 rtl/rd_buf_reader.sv | 134 +++++++++++++
 tb/tb_rd_buf_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_buf_reader.sv
// Read requester for the arbitrated sample SRAM: one byte per rd_start, ACC_CYC+3 cycles uncontended, retried on write pre-emption.
// No backpressure on rd_valid; rd_start is ignored while busy. Define RD_BUF_READER_TIMEOUT_EN to add the grant timeout and rd_err.
module rd_buf_reader #(
  parameter int AW      = 17,
  parameter int DW      = 8,
  parameter int ACC_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          addr_load,
  input  logic [AW-1:0] addr_in,
  input  logic          rd_start,
  output logic          rd_busy,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_req,
  input  logic          rd_sta,
  input  logic          wr_sta,
  output logic [AW-1:0] sram_addr,
  output logic          sram_oe_n,
  input  logic [DW-1:0] sram_din
`ifdef RD_BUF_READER_TIMEOUT_EN
  ,
  output logic          rd_err
`endif
);

  localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_GNT,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] acc_cnt;
  logic          start_pend;
`ifdef RD_BUF_READER_TIMEOUT_EN
  logic [7:0]    gnt_tmr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      acc_cnt    <= '0;
      start_pend <= 1'b0;
      rd_busy    <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_req     <= 1'b0;
      sram_addr  <= '0;
      sram_oe_n  <= 1'b1;
`ifdef RD_BUF_READER_TIMEOUT_EN
      gnt_tmr    <= '0;
      rd_err     <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      rd_req   <= 1'b0;
`ifdef RD_BUF_READER_TIMEOUT_EN
      rd_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          start_pend <= 1'b0;
          // A pointer load takes precedence and swallows any start in the same cycle
          if (addr_load) begin
            rd_ptr <= addr_in;
          end else if (rd_start || start_pend) begin
            state   <= REQ;
            rd_busy <= 1'b1;
            rd_req  <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT_GNT;
`ifdef RD_BUF_READER_TIMEOUT_EN
          gnt_tmr <= '0;
`endif
        end
        WAIT_GNT: begin
          if (rd_sta) begin
            state     <= ACCESS;
            acc_cnt   <= '0;
            sram_oe_n <= 1'b0;
            sram_addr <= rd_ptr;
`ifdef RD_BUF_READER_TIMEOUT_EN
          end else if (gnt_tmr == 8'd254) begin
            // 255th ungranted cycle: complete with a zero byte and flag the error
            state    <= DONE;
            rd_data  <= '0;
            rd_valid <= 1'b1;
            rd_err   <= 1'b1;
            rd_busy  <= 1'b0;
          end else begin
            gnt_tmr <= gnt_tmr + 8'd1;
`endif
          end
        end
        ACCESS: begin
          // A write owning the bus beats even the sampling edge; the byte is re-read
          if (wr_sta) begin
            state     <= REQ;
            rd_req    <= 1'b1;
            sram_oe_n <= 1'b1;
            acc_cnt   <= '0;
          end else if (acc_cnt == CNT_LAST) begin
            state     <= DONE;
            rd_data   <= sram_din;
            rd_valid  <= 1'b1;
            sram_oe_n <= 1'b1;
            rd_busy   <= 1'b0;
            rd_ptr    <= rd_ptr + 1'b1;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        DONE: begin
          // A start arriving alongside rd_valid is carried into IDLE
          state      <= IDLE;
          start_pend <= rd_start;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_buf_reader.sv
// Directed bench for rd_buf_reader with a per-read scoreboard and a bench-driven arbiter/SRAM.
module tb_rd_buf_reader;
  localparam int AW = 17;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          addr_load;
  logic [AW-1:0] addr_in;
  logic          rd_start;
  logic          rd_busy;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_req;
  logic          rd_sta;
  logic          wr_sta;
  logic [AW-1:0] sram_addr;
  logic          sram_oe_n;
  logic [DW-1:0] sram_din;
`ifdef RD_BUF_READER_TIMEOUT_EN
  logic          rd_err;
`endif

  rd_buf_reader #(.AW(AW), .DW(DW), .ACC_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_load (addr_load),
    .addr_in   (addr_in),
    .rd_start  (rd_start),
    .rd_busy   (rd_busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_req    (rd_req),
    .rd_sta    (rd_sta),
    .wr_sta    (wr_sta),
    .sram_addr (sram_addr),
    .sram_oe_n (sram_oe_n),
    .sram_din  (sram_din)
`ifdef RD_BUF_READER_TIMEOUT_EN
    ,
    .rd_err    (rd_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            err;
  } exp_t;

  int            n_chk = 0;
  int            n_fail = 0;
  int            n_req = 0;
  exp_t          exp_q[$];
  logic [AW-1:0] m_ptr;
  logic [AW-1:0] last_acc;
  bit            prev_req;
  bit            ld_ok = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: pointer advances once per good byte, loads only when the bench expects acceptance
  always @(negedge clk) begin
    if (rst) begin
      m_ptr    = '0;
      last_acc = '0;
      prev_req = 1'b0;
    end else begin
      if (addr_load && ld_ok) m_ptr = addr_in;
      if (!sram_oe_n) begin
        last_acc = m_ptr;
        chk("acc_addr", 32'(sram_addr), 32'(m_ptr));
      end else begin
        chk("addr_hold", 32'(sram_addr), 32'(last_acc));
      end
      if (rd_req) begin
        n_req++;
        chk("req_single", 32'(prev_req), 32'd0);
      end
      prev_req = rd_req;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_valid: rd_data %0h, no read outstanding", rd_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e.d));
          chk("busy_at_valid", 32'(rd_busy), 32'd0);
`ifdef RD_BUF_READER_TIMEOUT_EN
          chk("rd_err", 32'(rd_err), 32'(e.err));
`endif
          if (!e.err) m_ptr = m_ptr + 1'b1;
        end
      end
    end
  end

  // Runs one read while acting as arbiter (grant one cycle after rd_req) and SRAM
  task automatic do_read(input logic [DW-1:0] good, input logic [DW-1:0] bad, input bit pre,
                         input bit pulse, input bit chain, input bit no_gnt, input int extra_at,
                         output int lat, output logic [AW-1:0] acc);
    bit first = 1'b1;
    bit done = 1'b0;
    bit gnt_next = 1'b0;
    int acc_n = 0;
    lat = -1;
    acc = '0;
    if (pulse) rd_start = 1'b1;
    sram_din = pre ? bad : good;
    for (int i = 1; i <= 400 && !done; i++) begin
      tick;
      rd_start  = 1'b0;
      addr_load = 1'b0;
      wr_sta    = 1'b0;
      rd_sta    = gnt_next && !no_gnt;
      gnt_next  = rd_req;
      if (i == extra_at) begin
        rd_start  = 1'b1;
        addr_load = 1'b1;
        addr_in   = 17'h00100;
      end
      if (!sram_oe_n) begin
        acc_n++;
        acc = sram_addr;
      end
      if (pre && !first) sram_din = good;
      if (pre && first && acc_n == 2) begin
        wr_sta = 1'b1;
        first  = 1'b0;
      end
      if (rd_valid) begin
        done = 1'b1;
        lat  = i;
        if (chain) rd_start = 1'b1;
      end
    end
    rd_sta = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL read_timeout: no rd_valid within 400 cycles, expected one");
    end
  endtask

  int            lat;
  int            r0;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc2;
  bit            gn;

  initial begin
    rst = 1'b1; addr_load = 1'b0; addr_in = '0; rd_start = 1'b0;
    rd_sta = 1'b0; wr_sta = 1'b0; sram_din = '0;
    #12;
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_req", 32'(rd_req), 32'd0);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick;

    // Single uncontended read
    exp_q.push_back('{8'hA5, 1'b0});
    r0 = n_req;
    do_read(8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, acc);
    chk("lat_single", 32'(lat), 32'd5);
    chk("data_a5", 32'(rd_data), 32'hA5);
    chk("addr_first", 32'(acc), 32'd0);
    chk("req_count_single", 32'(n_req - r0), 32'd1);
    tick;

    // Pointer load at the top of the space, then wrap
    addr_in = 17'h1FFFF; addr_load = 1'b1; ld_ok = 1'b1;
    tick;
    addr_load = 1'b0; ld_ok = 1'b0;
    exp_q.push_back('{8'h11, 1'b0});
    do_read(8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, acc);
    chk("addr_top", 32'(acc), 32'h1FFFF);
    chk("data_11", 32'(rd_data), 32'h11);
    tick;
    exp_q.push_back('{8'h22, 1'b0});
    do_read(8'h22, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, acc);
    chk("addr_wrap", 32'(acc), 32'h00000);
    chk("data_22", 32'(rd_data), 32'h22);
    tick;

    // Write pre-empts on the sampling cycle, then a clean retry
    exp_q.push_back('{8'h3C, 1'b0});
    r0 = n_req;
    do_read(8'h3C, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 0, lat, acc);
    chk("lat_retry", 32'(lat), 32'd9);
    chk("req_count_retry", 32'(n_req - r0), 32'd2);
    chk("data_3c", 32'(rd_data), 32'h3C);
    chk("addr_retry", 32'(acc), 32'd1);
    tick;

    // rd_start and addr_load while busy are ignored
    exp_q.push_back('{8'h5A, 1'b0});
    r0 = n_req;
    do_read(8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2, lat, acc);
    chk("req_count_busy", 32'(n_req - r0), 32'd1);
    chk("addr_after_retry", 32'(acc), 32'd2);
    tick;

    // Load and start together in IDLE: load taken, no read started
    r0 = n_req;
    addr_in = 17'h0ABCD; addr_load = 1'b1; rd_start = 1'b1; ld_ok = 1'b1;
    tick;
    addr_load = 1'b0; rd_start = 1'b0; ld_ok = 1'b0;
    tick; tick; tick;
    chk("busy_after_load", 32'(rd_busy), 32'd0);
    chk("req_count_load", 32'(n_req - r0), 32'd0);
    exp_q.push_back('{8'h77, 1'b0});
    do_read(8'h77, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, acc);
    chk("addr_loaded", 32'(acc), 32'h0ABCD);
    tick;

    // Back-to-back: next rd_start in the rd_valid cycle
    exp_q.push_back('{8'h81, 1'b0});
    exp_q.push_back('{8'h82, 1'b0});
    do_read(8'h81, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0, lat, acc);
    do_read(8'h82, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, lat, acc2);
    chk("b2b_addr0", 32'(acc), 32'h0ABCE);
    chk("b2b_addr1", 32'(acc2), 32'h0ABCF);
    chk("b2b_data", 32'(rd_data), 32'h82);
    tick;

    // Reset during ACCESS aborts with no rd_valid
    gn = 1'b0;
    rd_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      rd_start = 1'b0;
      rd_sta = gn;
      gn = rd_req;
      if (!sram_oe_n) break;
    end
    chk("oe_before_rst", 32'(sram_oe_n), 32'd0);
    rd_sta = 1'b0; sram_din = 8'hEE;
    rst = 1'b1;
    #1;
    chk("arst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("arst_busy", 32'(rd_busy), 32'd0);
    chk("arst_req", 32'(rd_req), 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    exp_q.push_back('{8'hC3, 1'b0});
    do_read(8'hC3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, acc);
    chk("addr_after_rst", 32'(acc), 32'd0);
    chk("data_c3", 32'(rd_data), 32'hC3);
    tick;

`ifdef RD_BUF_READER_TIMEOUT_EN
    // Grant never arrives: zero byte with rd_err, pointer held
    exp_q.push_back('{8'h00, 1'b1});
    do_read(8'h99, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0, lat, acc);
    chk("lat_timeout", 32'(lat), 32'd257);
    chk("data_timeout", 32'(rd_data), 32'd0);
    tick;
    exp_q.push_back('{8'h4D, 1'b0});
    do_read(8'h4D, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, acc);
    chk("addr_after_timeout", 32'(acc), 32'd1);
    tick;
`endif

    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
